mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit of the 5-stage MIPS pipeline; sits between the EX/MEM register and the register-file write port.
- Executes sw/sh/sb and lw/lh/lhu/lb/lbu against an internal word-organised data memory.
- Produces the registered MEM/WB payload (PC, rd, RegWrite, write-back data) consumed by the WB stage.
- Data base address 0x0000_0000; byte-addressed, little-endian.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data memory; must be a power of 2.
- AW, 10, word-index width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- MEM_PC  in  32  PC of the instruction in MEM.
- MEM_MemRead  in  1  load in MEM.
- MEM_MemWrite  in  1  store in MEM.
- MEM_MemOp  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned. Stores use 000/001/011 only.
- MEM_addr  in  32  effective byte address (ALU result).
- MEM_wdata  in  32  store data (rt, already forwarded).
- MEM_aluResult  in  32  non-memory write-back value.
- MEM_RegWrite  in  1  instruction writes rd.
- MEM_rd  in  5  destination register.
- stall  in  1  hold MEM/WB register contents.
- WB_PC  out  32  registered MEM_PC.
- WB_RegWrite  out  1  registered write enable.
- WB_rd  out  5  registered destination.
- WB_wdata  out  32  registered write-back data.
- WB_misalign  out  1  registered misaligned-access flag.

Behaviour:
- Memory array is named dataMem, word-indexed as dataMem[MEM_addr[AW+1:2]]. Benches read it hierarchically as dataMem[byteaddr/4].
- Addresses above the array wrap modulo DEPTH words; upper bits are ignored.
- Store: byte-lane write at the rising edge when MEM_MemWrite=1, MEM_MemWrite is not masked by misalignment, and rst=0.
  - SW writes all 4 lanes.
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SB writes lane addr[1:0] with wdata[7:0].
  - Unselected lanes keep their value.
- Load:
  - Read of dataMem is combinational in the same cycle; the selected lane(s) are extended and captured into WB_wdata at the edge.
  - Load-use latency is 1 cycle (result in WB the cycle after MEM).
  - LH and LB sign-extend; LHU and LBU zero-extend.
- Non-memory instructions: WB_wdata <= MEM_aluResult.
- Store followed by a load to the same word on the next cycle must return the new data. The write has landed at the preceding edge, so no bypass is needed.
- Misalignment:
  - Word access with addr[1:0]!=0 is misaligned; halfword access with addr[0]=1 is misaligned.
  - A misaligned store writes nothing.
  - A misaligned load forces WB_RegWrite=0.
  - Either case sets WB_misalign=1 for that one WB cycle; no trap.
- MemRead and MemWrite both high is illegal. Treat it as a store and assert WB_misalign=1.
- stall=1 holds all WB_* outputs and suppresses the memory write.
- Reset:
  - All WB_* outputs become 0 at the first edge with rst=1.
  - A store presented during reset is discarded.
  - dataMem contents are NOT cleared (preload and post-run inspection depend on this).
- Reset asserted mid-load: the in-flight WB payload is dropped and outputs are 0 the next cycle.

Decomposition:
- Shared package mips_defs: MemOp encodings, data base address constant.
- One sub-module, lsu_lane_ext: combinational load lane select plus sign/zero extension. Inputs: word, addr[1:0], MemOp. Output: 32-bit value.
- Store byte-enable generation, dataMem and the MEM/WB registers stay in the top.

Test Plan:
- Store then load: SW 0x12345678 @0x0, then LW @0x0 next cycle -> WB_wdata=0x12345678 one cycle later, WB_RegWrite=1.
- Byte stores: SB 0xAB @0x5, SB 0xCD @0x6 over a word preset to 0 -> dataMem[1]=0x00CDAB00.
  - LB @0x5 -> 0xFFFFFFAB.
  - LBU @0x5 -> 0x000000AB.
- Halfword: SH 0x8001 @0xA over dataMem[2]=0x11112222 -> dataMem[2]=0x80012222.
  - LH @0xA -> 0xFFFF8001.
  - LHU @0xA -> 0x00008001.
- Misalignment: LW @0x2 -> WB_RegWrite=0, WB_misalign=1. SH @0x3 -> memory unchanged, WB_misalign=1.
- Wrap and non-memory: SW 0xDEADBEEF @ (DEPTH*4) -> dataMem[0]=0xDEADBEEF. ALU op with aluResult 0x7 -> WB_wdata=0x7.
- Stall and reset: stall=1 during SW -> no write, WB_* held. rst=1 mid-LW -> WB_* all 0 next cycle, dataMem retained.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: memory access encodings and data-segment base.
package mips_defs;

  localparam logic [31:0] DATA_BASE = 32'h0000_0000;

  typedef enum logic [2:0] {
    MEMOP_WORD  = 3'b000,
    MEMOP_HALF  = 3'b001,
    MEMOP_HALFU = 3'b010,
    MEMOP_BYTE  = 3'b011,
    MEMOP_BYTEU = 3'b100
  } mem_op_e;

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      MEMOP_WORD:               return lane != 2'b00;
      MEMOP_HALF, MEMOP_HALFU:  return lane[0];
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_ext.sv
// Load lane select plus sign/zero extension of a little-endian memory word.
module lsu_lane_ext
  import mips_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  mem_op,
  output logic [31:0] result
);

  logic [15:0] half;
  logic [7:0]  byte_val;

  assign half     = addr[1] ? word[31:16] : word[15:0];
  assign byte_val = word[8*addr +: 8];

  always_comb begin
    result = word;
    case (mem_op)
      MEMOP_HALF:  result = {{16{half[15]}}, half};
      MEMOP_HALFU: result = {16'h0000, half};
      MEMOP_BYTE:  result = {{24{byte_val[7]}}, byte_val};
      MEMOP_BYTEU: result = {24'h000000, byte_val};
      default:     result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: byte-lane data memory plus the MEM/WB pipeline register.
module mem_stage_lsu
  import mips_defs::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_PC,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [2:0]  MEM_MemOp,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_wdata,
  input  logic [31:0] MEM_aluResult,
  input  logic        MEM_RegWrite,
  input  logic [4:0]  MEM_rd,
  input  logic        stall,
  output logic [31:0] WB_PC,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_rd,
  output logic [31:0] WB_wdata,
  output logic        WB_misalign
);

  logic [31:0]   dataMem [DEPTH];

  logic [31:0]   offs;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          unused_addr_bits;
  logic          access, illegal, misalign, is_load, do_write;
  logic [3:0]    be;
  logic [31:0]   st_data, rd_word, ld_value, wb_data;

  // Upper address bits are ignored so out-of-range addresses wrap.
  assign offs             = MEM_addr - DATA_BASE;
  assign word_idx         = offs[AW+1:2];
  assign lane             = offs[1:0];
  assign unused_addr_bits = ^offs[31:AW+2];

  always_comb begin
    access   = MEM_MemRead | MEM_MemWrite;
    illegal  = MEM_MemRead & MEM_MemWrite;
    misalign = access & is_misaligned(MEM_MemOp, lane);
    is_load  = MEM_MemRead & ~MEM_MemWrite;
    do_write = MEM_MemWrite & ~misalign & ~stall & ~rst;
    be       = 4'b0000;
    st_data  = MEM_wdata;
    case (MEM_MemOp)
      MEMOP_WORD: begin
        be      = 4'b1111;
        st_data = MEM_wdata;
      end
      MEMOP_HALF, MEMOP_HALFU: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{MEM_wdata[15:0]}};
      end
      default: begin
        be      = 4'b0001 << lane;
        st_data = {4{MEM_wdata[7:0]}};
      end
    endcase
  end

  // No reset on the array: preloaded contents must survive rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) dataMem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign rd_word = dataMem[word_idx];

  lsu_lane_ext u_lane_ext (
    .word   (rd_word),
    .addr   (lane),
    .mem_op (MEM_MemOp),
    .result (ld_value)
  );

  assign wb_data = is_load ? ld_value : MEM_aluResult;

  // stall holds the payload; a store sent during stall is dropped by do_write.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_PC       <= 32'h0;
      WB_RegWrite <= 1'b0;
      WB_rd       <= 5'd0;
      WB_wdata    <= 32'h0;
      WB_misalign <= 1'b0;
    end else if (!stall) begin
      WB_PC       <= MEM_PC;
      WB_RegWrite <= MEM_RegWrite & ~(is_load & misalign);
      WB_rd       <= MEM_rd;
      WB_wdata    <= wb_data;
      WB_misalign <= misalign | illegal;
    end
  end

endmodule
